// File: rtl/float_splitter.sv
// float_splitter: splits an IEEE 754 single x into floor integer part and
// fraction, x = IntOut + FracOut/2^FRACW, with saturation on overflow/Inf/NaN.
// Ports: Clock, Reset (async, active high), Start/Datain request,
//        Busy, DataOut_vld pulse, IntOut (signed), FracOut (Q0.FRACW), Sat.
module float_splitter #(
    parameter int BITWIDTH = 32,
    parameter int IWIDTH   = 8,
    parameter int FRACW    = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [BITWIDTH-1:0] Datain,
    output logic                Busy,
    output logic                DataOut_vld,
    output logic [IWIDTH-1:0]   IntOut,
    output logic [FRACW-1:0]    FracOut,
    output logic                Sat
);

    localparam int W  = IWIDTH + FRACW;
    // 24 guard bits below the fixed-point LSB catch every discarded
    // mantissa bit for the sticky OR.
    localparam int BW = W + 24;

    // |x| >= 2^(IWIDTH-1) once the biased exponent reaches this value.
    localparam logic [7:0] E_SAT  = 8'(126 + IWIDTH);
    // Below this exponent the whole mantissa lies under the LSB.
    localparam logic [7:0] E_TINY = 8'(127 - FRACW);
    // Shift that places mantissa bit 0 in the guard field.
    localparam logic [9:0] SH_OFF = 10'(126 - FRACW);

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        FIXUP
    } state_t;

    state_t state, state_nxt;

    logic          sgn_r;
    logic [7:0]    exp_r;
    logic [22:0]   man_r;

    logic [W-1:0]  mag_r;
    logic          sticky_r;
    logic          sat_r;

    logic [9:0]    shamt;
    logic [BW-1:0] shifted;
    logic [W-1:0]  val;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = ALIGN;
            ALIGN:   state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    // Operand capture on the accepting edge
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sgn_r <= 1'b0;
            exp_r <= 8'd0;
            man_r <= 23'd0;
        end else if (state == IDLE && Start) begin
            sgn_r <= Datain[31];
            exp_r <= Datain[30:23];
            man_r <= Datain[22:0];
        end
    end

    // Barrel shift; only meaningful for E_TINY <= exp_r < E_SAT,
    // where shamt is always in 1..W-1.
    always_comb begin
        shamt   = {2'b00, exp_r} - SH_OFF;
        shifted = {{W{1'b0}}, 1'b1, man_r} << shamt;
    end

    // Alignment: magnitude, sticky and saturation flag
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mag_r    <= '0;
            sticky_r <= 1'b0;
            sat_r    <= 1'b0;
        end else if (state == ALIGN) begin
            sat_r <= (exp_r >= E_SAT);
            if (exp_r == 8'd0 || exp_r >= E_SAT) begin
                mag_r    <= '0;
                sticky_r <= 1'b0;
            end else if (exp_r < E_TINY) begin
                mag_r    <= '0;
                sticky_r <= 1'b1;
            end else begin
                mag_r    <= shifted[BW-1:24];
                sticky_r <= |shifted[23:0];
            end
        end
    end

    // Negative values round toward -inf: any lost bit bumps the
    // magnitude before negation.
    always_comb begin
        val = mag_r;
        if (sgn_r) begin
            val = '0 - (mag_r + {{(W-1){1'b0}}, sticky_r});
        end
    end

    // Result registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            DataOut_vld <= 1'b0;
            IntOut      <= '0;
            FracOut     <= '0;
            Sat         <= 1'b0;
        end else begin
            DataOut_vld <= 1'b0;
            if (state == FIXUP) begin
                DataOut_vld <= 1'b1;
                Sat         <= sat_r;
                if (sat_r) begin
                    if (sgn_r) begin
                        IntOut  <= {1'b1, {(IWIDTH-1){1'b0}}};
                        FracOut <= '0;
                    end else begin
                        IntOut  <= {1'b0, {(IWIDTH-1){1'b1}}};
                        FracOut <= '1;
                    end
                end else begin
                    IntOut  <= val[W-1:FRACW];
                    FracOut <= val[FRACW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_float_splitter.sv
// tb_float_splitter: directed and random checks of float_splitter
// against an arithmetic floor(x * 2^FRACW) reference.
module tb_float_splitter;

    localparam int IW = 8;
    localparam int FW = 16;

    logic          Clock;
    logic          Reset;
    logic          Start;
    logic [31:0]   Datain;
    logic          Busy;
    logic          DataOut_vld;
    logic [IW-1:0] IntOut;
    logic [FW-1:0] FracOut;
    logic          Sat;

    int n_chk  = 0;
    int n_fail = 0;

    float_splitter #(
        .BITWIDTH(32),
        .IWIDTH  (IW),
        .FRACW   (FW)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Datain     (Datain),
        .Busy       (Busy),
        .DataOut_vld(DataOut_vld),
        .IntOut     (IntOut),
        .FracOut    (FracOut),
        .Sat        (Sat)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: floor(x * 2^FW) from the float fields with plain
    // integer arithmetic, then split / clamp.
    function automatic logic [31:0] model(input logic [31:0] x);
        logic       s;
        int         e;
        longint     mant;
        longint     q;
        longint     v;
        int         sh;
        int         k;
        logic       lost;
        logic [7:0] io;
        logic [15:0] fo;
        s    = x[31];
        e    = int'(x[30:23]);
        mant = longint'({1'b1, x[22:0]});
        if (e == 0) return 32'h0;
        if (e >= 127 + IW - 1) begin
            if (s) return {7'd0, 1'b1, 8'h80, 16'h0000};
            return {7'd0, 1'b1, 8'h7F, 16'hFFFF};
        end
        sh = e - 150 + FW;
        if (sh >= 0) begin
            q    = mant <<< sh;
            lost = 1'b0;
        end else begin
            k = -sh;
            if (k >= 40) begin
                q    = 0;
                lost = 1'b1;
            end else begin
                q    = mant >>> k;
                lost = ((q <<< k) != mant);
            end
        end
        v  = s ? -(q + (lost ? 64'sd1 : 64'sd0)) : q;
        io = 8'(v >>> FW);
        fo = 16'(v);
        return {7'd0, 1'b0, io, fo};
    endfunction

    function automatic logic [31:0] pack_out();
        return {7'd0, Sat, IntOut, FracOut};
    endfunction

    task automatic do_conv(input logic [31:0] d, output logic [31:0] res,
                           output int lat);
        int i;
        @(negedge Clock);
        Start  = 1'b1;
        Datain = d;
        @(posedge Clock);
        #1;
        Start  = 1'b0;
        Datain = $urandom;
        lat = 0;
        res = 32'hDEAD_BEEF;
        i = 0;
        while (lat == 0 && i < 6) begin
            @(negedge Clock);
            i++;
            if (DataOut_vld) begin
                lat = i;
                res = pack_out();
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] d);
        logic [31:0] res;
        int          lat;
        do_conv(d, res, lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, res, model(d));
    endtask

    task automatic run_fixed(input string tag, input logic [31:0] d,
                             input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        do_conv(d, res, lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check(tag, res, exp);
        check({tag, "_mdl"}, model(d), exp);
    endtask

    function automatic logic [31:0] rand_float();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: x[30:23] = 8'($urandom_range(100, 140));
            2: begin
                x[30:23] = 8'($urandom_range(127, 133));
                x[15:0]  = 16'h0;
            end
            default: x[30:23] = 8'($urandom_range(108, 136));
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] a[6];
        logic [31:0] got_q[$];
        int          pulses;

        Reset  = 1'b1;
        Start  = 1'b0;
        Datain = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_out", pack_out(), 32'h0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_vld", {31'd0, DataOut_vld}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;

        run_fixed("p2_5",   32'h40200000, 32'h0002_8000);
        run_fixed("m2_5",   32'hC0200000, 32'h00FD_8000);
        run_fixed("m1",     32'hBF800000, 32'h00FF_0000);
        run_fixed("p8",     32'h41000000, 32'h0008_0000);
        run_fixed("m_tiny", 32'hB5800000, 32'h00FF_FFFF);
        run_fixed("p_tiny", 32'h35800000, 32'h0000_0000);
        run_fixed("m_den",  32'h80000001, 32'h0000_0000);
        run_fixed("p128",   32'h43000000, 32'h017F_FFFF);
        run_fixed("m128",   32'hC3000000, 32'h0180_0000);
        run_fixed("m_inf",  32'hFF800000, 32'h0180_0000);
        run_fixed("nan",    32'h7FC00000, 32'h017F_FFFF);
        run_fixed("m127_5", 32'hC2FF0000, 32'h0080_8000);
        run_fixed("p127_5", 32'h42FF0000, 32'h007F_8000);

        for (int i = 0; i < 300; i++) begin
            run_one("rnd", rand_float());
        end

        // Start held for six cycles: only cycles 0 and 3 are accepted
        for (int c = 0; c < 6; c++) a[c] = rand_float();
        @(negedge Clock);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge Clock);
            check("b2b_busy", {31'd0, Busy}, {31'd0, (c % 3) != 0});
            if (DataOut_vld) got_q.push_back(pack_out());
            Start  = 1'b1;
            Datain = a[c];
        end
        @(negedge Clock);
        Start = 1'b0;
        if (DataOut_vld) got_q.push_back(pack_out());
        repeat (5) begin
            @(negedge Clock);
            if (DataOut_vld) got_q.push_back(pack_out());
        end
        check("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_res0", got_q[0], model(a[0]));
            check("b2b_res1", got_q[1], model(a[3]));
        end

        // Reset in the middle of a conversion
        run_fixed("pre_rst", 32'h40200000, 32'h0002_8000);
        @(negedge Clock);
        Start  = 1'b1;
        Datain = 32'hC0200000;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("mid_busy", {31'd0, Busy}, 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("mid_rst_out", pack_out(), 32'h0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        check("mid_rst_vld", {31'd0, DataOut_vld}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge Clock);
            if (DataOut_vld) pulses++;
        end
        check("mid_rst_novld", 32'(pulses), 32'd0);
        check("mid_rst_hold", pack_out(), 32'h0);
        run_fixed("post_rst", 32'hC0200000, 32'h00FD_8000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
